// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory port between fetch (I) and data (D) requesters,
// with a BUSY-cycle watchdog that forces completion if the memory never acknowledges.
module mem_arbiter #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic [31:0] i_rdata,
  output logic        i_ack,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [3:0]  d_be,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_ack,
  output logic        mem_req,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        timeout_err
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] BUSY_I = 2'd1;
  localparam logic [1:0] BUSY_D = 2'd2;
  localparam logic [7:0] TMAX   = 8'(TIMEOUT - 1);

  logic [1:0] state;
  logic       last_d;
  logic [7:0] cnt;
  logic       i_elig, d_elig, grant_i, grant_d;

  // A requester whose ack is on the wire this cycle has not yet had a chance to drop req.
  always_comb begin
    i_elig  = i_req && !i_ack;
    d_elig  = d_req && !d_ack;
    grant_i = i_elig && (!d_elig || last_d);
    grant_d = d_elig && (!i_elig || !last_d);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      last_d      <= 1'b1;
      cnt         <= '0;
      i_rdata     <= '0;
      i_ack       <= 1'b0;
      d_rdata     <= '0;
      d_ack       <= 1'b0;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_be      <= '0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      timeout_err <= 1'b0;
    end else begin
      i_ack       <= 1'b0;
      d_ack       <= 1'b0;
      timeout_err <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_i) begin
            state     <= BUSY_I;
            mem_req   <= 1'b1;
            mem_we    <= 1'b0;
            mem_be    <= 4'b1111;
            mem_addr  <= i_addr;
            mem_wdata <= '0;
            last_d    <= 1'b0;
            cnt       <= '0;
          end else if (grant_d) begin
            state     <= BUSY_D;
            mem_req   <= 1'b1;
            mem_we    <= d_we;
            mem_be    <= d_be;
            mem_addr  <= d_addr;
            mem_wdata <= d_wdata;
            last_d    <= 1'b1;
            cnt       <= '0;
          end
        end
        BUSY_I, BUSY_D: begin
          if (mem_ack) begin
            state   <= IDLE;
            mem_req <= 1'b0;
            if (state == BUSY_I) begin
              i_ack   <= 1'b1;
              i_rdata <= mem_rdata;
            end else begin
              d_ack <= 1'b1;
              if (!mem_we) d_rdata <= mem_rdata;
            end
          end else if (cnt == TMAX) begin
            // Watchdog: complete with zero data so the requester is never stuck.
            state       <= IDLE;
            mem_req     <= 1'b0;
            timeout_err <= 1'b1;
            if (state == BUSY_I) begin
              i_ack   <= 1'b1;
              i_rdata <= '0;
            end else begin
              d_ack   <= 1'b1;
              d_rdata <= '0;
            end
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: stimulus pushes expected memory commands and acks,
// monitors pop and compare whenever the DUTs present them.
module tb_mem_arbiter;

  typedef struct {
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } cmd_t;

  typedef struct {
    logic        is_d;
    logic [31:0] rdata;
    logic        terr;
    int          gap;
  } ack_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_req, d_req, d_we, mem_ack;
  logic [31:0] i_addr, d_addr, d_wdata, mem_rdata;
  logic [3:0]  d_be;
  logic [31:0] i_rdata, d_rdata, mem_addr, mem_wdata;
  logic        i_ack, d_ack, mem_req, mem_we, timeout_err;
  logic [3:0]  mem_be;

  logic        t_d_req, t_mem_ack;
  logic [31:0] t_d_addr, t_mem_rdata;
  logic [31:0] t_i_rdata, t_d_rdata, t_mem_addr, t_mem_wdata;
  logic        t_i_ack, t_d_ack, t_mem_req, t_mem_we, t_timeout_err;
  logic [3:0]  t_mem_be;

  int   n_vec = 0;
  int   n_miss = 0;
  cmd_t cmd_q[$];
  ack_t ack_q[$];
  ack_t t_q[$];
  int   ack_count = 0;

  int          lat = 0;
  bit          mem_en = 1'b1;
  bit          use_fixed = 1'b0;
  bit          idle_poke = 1'b0;
  logic [31:0] fixed_val = '0;
  int          mcnt = 0;
  int          t_lat = 0;
  bit          t_en = 1'b1;
  int          tcnt = 0;
  logic [31:0] t_exp_addr = '0;

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk(clk), .reset(rst_n),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ack(d_ack),
    .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .timeout_err(timeout_err)
  );

  mem_arbiter #(.TIMEOUT(4)) dut_to (
    .clk(clk), .reset(rst_n),
    .i_req(1'b0), .i_addr(32'h0), .i_rdata(t_i_rdata), .i_ack(t_i_ack),
    .d_req(t_d_req), .d_we(1'b0), .d_be(4'hF), .d_addr(t_d_addr), .d_wdata(32'h0),
    .d_rdata(t_d_rdata), .d_ack(t_d_ack),
    .mem_req(t_mem_req), .mem_we(t_mem_we), .mem_be(t_mem_be), .mem_addr(t_mem_addr),
    .mem_wdata(t_mem_wdata), .mem_rdata(t_mem_rdata), .mem_ack(t_mem_ack),
    .timeout_err(t_timeout_err)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic bound_fail(input string nm);
    n_vec++;
    n_miss++;
    $display("FAIL %s: wait bound expired", nm);
  endtask

  // Memory models: ack arrives after 'lat' non-ack cycles of mem_req.
  always @(posedge clk) begin
    #1;
    if (mem_req && mem_en) begin
      mem_ack   = (mcnt == lat);
      mem_rdata = !mem_ack ? 32'hBAD0BAD0 : use_fixed ? fixed_val : {mem_addr[15:0], 16'hC0DE};
      mcnt++;
    end else begin
      mcnt      = 0;
      mem_ack   = idle_poke;
      mem_rdata = idle_poke ? 32'hBAD0BAD0 : 32'h0;
    end
  end

  always @(posedge clk) begin
    #1;
    if (t_mem_req && t_en) begin
      t_mem_ack   = (tcnt == t_lat);
      t_mem_rdata = t_mem_ack ? 32'h55AA55AA : 32'h0;
      tcnt++;
    end else begin
      tcnt        = 0;
      t_mem_ack   = 1'b0;
      t_mem_rdata = 32'h0;
    end
  end

  // Monitor for the main instance.
  initial begin
    cmd_t cur;
    ack_t e;
    logic prev_req;
    int   cyc, last_ack;
    prev_req = 1'b0;
    cyc      = 0;
    last_ack = 0;
    cur      = '{we: 1'b0, be: 4'h0, addr: 32'h0, wdata: 32'h0};
    forever begin
      @(posedge clk);
      #2;
      cyc++;
      if (mem_req && !prev_req) begin
        if (cmd_q.size() == 0) begin
          bound_fail("unexpected_mem_req");
        end else begin
          cur = cmd_q.pop_front();
          chk("cmd_we", 32'(mem_we), 32'(cur.we));
          chk("cmd_be", 32'(mem_be), 32'(cur.be));
          chk("cmd_addr", mem_addr, cur.addr);
          chk("cmd_wdata", mem_wdata, cur.wdata);
        end
      end else if (mem_req && prev_req) begin
        if ({mem_we, mem_be, mem_addr, mem_wdata} !== {cur.we, cur.be, cur.addr, cur.wdata}) begin
          chk("cmd_stable_addr", mem_addr, cur.addr);
          chk("cmd_stable_wdata", mem_wdata, cur.wdata);
          chk("cmd_stable_webe", 32'({mem_we, mem_be}), 32'({cur.we, cur.be}));
        end
      end
      prev_req = mem_req;
      if (i_ack && d_ack) bound_fail("double_ack");
      if (i_ack || d_ack) begin
        ack_count++;
        if (ack_q.size() == 0) begin
          bound_fail("unexpected_ack");
        end else begin
          e = ack_q.pop_front();
          chk("ack_port", 32'(d_ack), 32'(e.is_d));
          chk("ack_rdata", d_ack ? d_rdata : i_rdata, e.rdata);
          chk("ack_terr", 32'(timeout_err), 32'(e.terr));
          if (e.gap != 0) chk("ack_gap", 32'(cyc - last_ack), 32'(e.gap));
        end
        last_ack = cyc;
      end else if (timeout_err) begin
        bound_fail("terr_without_ack");
      end
    end
  end

  // Monitor for the TIMEOUT=4 instance.
  initial begin
    ack_t e;
    logic prev_req;
    prev_req = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      if (t_mem_req && !prev_req) begin
        chk("t_cmd_addr", t_mem_addr, t_exp_addr);
        chk("t_cmd_webe", 32'({t_mem_we, t_mem_be}), 32'h0F);
        chk("t_cmd_wdata", t_mem_wdata, 32'h0);
      end
      prev_req = t_mem_req;
      if (t_i_ack || t_d_ack) begin
        if (t_q.size() == 0) begin
          bound_fail("t_unexpected_ack");
        end else begin
          e = t_q.pop_front();
          chk("t_ack_port", 32'(t_d_ack), 32'(e.is_d));
          chk("t_ack_rdata", t_d_ack ? t_d_rdata : t_i_rdata, e.rdata);
          chk("t_ack_terr", 32'(t_timeout_err), 32'(e.terr));
        end
      end else if (t_timeout_err) begin
        bound_fail("t_terr_without_ack");
      end
    end
  end

  task automatic run_one(input bit is_d, input logic we, input logic [3:0] be,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         output int cyc, output int busy);
    bit got;
    got  = 1'b0;
    cyc  = 0;
    busy = 0;
    @(negedge clk);
    if (is_d) begin
      d_req = 1'b1; d_we = we; d_be = be; d_addr = addr; d_wdata = wdata;
    end else begin
      i_req = 1'b1; i_addr = addr;
    end
    for (int k = 0; k < 60 && !got; k++) begin
      @(negedge clk);
      cyc++;
      if (is_d ? d_ack : i_ack) begin
        got = 1'b1;
      end else begin
        if (mem_req) busy++;
        if (is_d && busy > 1) begin
          d_addr = $urandom; d_wdata = $urandom; d_be = 4'($urandom_range(15));
        end
      end
    end
    if (!got) bound_fail("run_one_ack");
    i_req = 1'b0;
    d_req = 1'b0;
  endtask

  task automatic run_t(input logic [31:0] addr, output int busy, output logic req_at_ack);
    bit got;
    got        = 1'b0;
    busy       = 0;
    req_at_ack = 1'b1;
    @(negedge clk);
    t_exp_addr = addr;
    t_d_addr   = addr;
    t_d_req    = 1'b1;
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge clk);
      if (t_d_ack) begin
        got        = 1'b1;
        req_at_ack = t_mem_req;
      end else if (t_mem_req) begin
        busy++;
      end
    end
    if (!got) bound_fail("run_t_ack");
    t_d_req = 1'b0;
  endtask

  initial begin
    int cyc, busy, target;
    logic req_at_ack;
    bit done_i, done_d;
    rst_n = 1'b0;
    i_req = 1'b0; i_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_be = '0; d_addr = '0; d_wdata = '0;
    t_d_req = 1'b0; t_d_addr = '0;
    repeat (3) @(negedge clk);
    chk("rst_mem_req", 32'(mem_req), 32'h0);
    chk("rst_acks", 32'({i_ack, d_ack, timeout_err}), 32'h0);
    chk("rst_i_rdata", i_rdata, 32'h0);
    chk("rst_d_rdata", d_rdata, 32'h0);
    chk("rst_mem_cmd", mem_addr | mem_wdata | 32'({mem_we, mem_be}), 32'h0);
    rst_n = 1'b1;

    // Single fetch, zero-wait memory.
    use_fixed = 1'b1; fixed_val = 32'hDEADBEEF; lat = 0;
    cmd_q.push_back('{we: 1'b0, be: 4'hF, addr: 32'h100, wdata: 32'h0});
    ack_q.push_back('{is_d: 1'b0, rdata: 32'hDEADBEEF, terr: 1'b0, gap: 0});
    run_one(1'b0, 1'b0, 4'h0, 32'h100, 32'h0, cyc, busy);
    chk("i_latency", 32'(cyc), 32'd2);
    chk("i_busy_cycles", 32'(busy), 32'd1);

    // Data read with one wait state, then a write whose ack must not touch d_rdata.
    use_fixed = 1'b0; lat = 1;
    cmd_q.push_back('{we: 1'b0, be: 4'hF, addr: 32'h400, wdata: 32'hCAFE0000});
    ack_q.push_back('{is_d: 1'b1, rdata: 32'h0400C0DE, terr: 1'b0, gap: 0});
    run_one(1'b1, 1'b0, 4'hF, 32'h400, 32'hCAFE0000, cyc, busy);
    chk("d_read_busy", 32'(busy), 32'd2);

    use_fixed = 1'b1; fixed_val = 32'hFFFFFFFF; lat = 4;
    cmd_q.push_back('{we: 1'b1, be: 4'b0011, addr: 32'h2000, wdata: 32'h12345678});
    ack_q.push_back('{is_d: 1'b1, rdata: 32'h0400C0DE, terr: 1'b0, gap: 0});
    run_one(1'b1, 1'b1, 4'b0011, 32'h2000, 32'h12345678, cyc, busy);
    chk("d_write_busy", 32'(busy), 32'd5);

    // Both requesters held high: alternate I, D, I, D with one ack every 2 cycles.
    use_fixed = 1'b0; lat = 0;
    for (int k = 0; k < 2; k++) begin
      cmd_q.push_back('{we: 1'b0, be: 4'hF, addr: 32'h500, wdata: 32'h0});
      cmd_q.push_back('{we: 1'b0, be: 4'h5, addr: 32'h600, wdata: 32'h0});
      ack_q.push_back('{is_d: 1'b0, rdata: 32'h0500C0DE, terr: 1'b0, gap: (k == 0) ? 0 : 2});
      ack_q.push_back('{is_d: 1'b1, rdata: 32'h0600C0DE, terr: 1'b0, gap: 2});
    end
    target = ack_count + 4;
    @(negedge clk);
    i_req = 1'b1; i_addr = 32'h500;
    d_req = 1'b1; d_we = 1'b0; d_be = 4'h5; d_addr = 32'h600; d_wdata = 32'h0;
    for (int k = 0; k < 30 && ack_count < target; k++) @(negedge clk);
    if (ack_count < target) bound_fail("alternate_acks");
    i_req = 1'b0; d_req = 1'b0;

    // mem_ack while idle must produce nothing.
    idle_poke = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("idle_ack_ignored", 32'({i_ack, d_ack, mem_req}), 32'h0);
    end
    idle_poke = 1'b0;

    // Reset in the middle of a data transaction.
    mem_en = 1'b0;
    cmd_q.push_back('{we: 1'b0, be: 4'hF, addr: 32'h800, wdata: 32'h0});
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b0; d_be = 4'hF; d_addr = 32'h800;
    repeat (3) @(negedge clk);
    chk("busy_before_reset", 32'(mem_req), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("reset_drops_mem_req", 32'(mem_req), 32'h0);
    chk("reset_no_d_ack", 32'(d_ack), 32'h0);
    i_req = 1'b1; i_addr = 32'h700;
    mem_en = 1'b1; lat = 0;
    cmd_q.push_back('{we: 1'b0, be: 4'hF, addr: 32'h700, wdata: 32'h0});
    cmd_q.push_back('{we: 1'b0, be: 4'hF, addr: 32'h800, wdata: 32'h0});
    ack_q.push_back('{is_d: 1'b0, rdata: 32'h0700C0DE, terr: 1'b0, gap: 0});
    ack_q.push_back('{is_d: 1'b1, rdata: 32'h0800C0DE, terr: 1'b0, gap: 2});
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    done_i = 1'b0; done_d = 1'b0;
    for (int k = 0; k < 20 && !(done_i && done_d); k++) begin
      @(negedge clk);
      if (i_ack) begin i_req = 1'b0; done_i = 1'b1; end
      if (d_ack) begin d_req = 1'b0; done_d = 1'b1; end
    end
    if (!(done_i && done_d)) bound_fail("post_reset_acks");
    i_req = 1'b0; d_req = 1'b0;

    // TIMEOUT=4 instance: ack on the last allowed cycle completes normally.
    t_en = 1'b1; t_lat = 3;
    t_q.push_back('{is_d: 1'b1, rdata: 32'h55AA55AA, terr: 1'b0, gap: 0});
    run_t(32'h3000, busy, req_at_ack);
    chk("t_late_ack_busy", 32'(busy), 32'd4);

    // No ack at all: forced completion after 4 BUSY cycles with zeroed data.
    t_en = 1'b0;
    t_q.push_back('{is_d: 1'b1, rdata: 32'h0, terr: 1'b1, gap: 0});
    run_t(32'h3004, busy, req_at_ack);
    chk("t_timeout_busy", 32'(busy), 32'd4);
    chk("t_timeout_mem_req", 32'(req_at_ack), 32'h0);
    @(negedge clk);
    chk("t_idle_after_timeout", 32'({t_mem_req, t_d_ack, t_timeout_err}), 32'h0);

    repeat (4) @(negedge clk);
    chk("cmd_q_drained", 32'(cmd_q.size()), 32'h0);
    chk("ack_q_drained", 32'(ack_q.size()), 32'h0);
    chk("t_q_drained", 32'(t_q.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: TIMEOUT, 255, BUSY cycles without mem_ack before forced completion (1..255).
REQ-002 Port: clk  in  1  single clock; all state updates on rising edge.
REQ-003 Port: reset  in  1  asynchronous, active-low reset.
REQ-004 Port: i_req  in  1  fetch request, level, held until i_ack.
REQ-005 Port: i_addr  in  32  fetch address, stable while i_req.
REQ-006 Port: i_rdata  out  32  fetched word, valid with i_ack.
REQ-007 Port: i_ack  out  1  fetch completion, one-cycle pulse.
REQ-008 Port: d_req  in  1  data request, level, held until d_ack.
REQ-009 Port: d_we  in  1  data write enable.
REQ-010 Port: d_be  in  4  data byte enables.
REQ-011 Port: d_addr  in  32  data address.
REQ-012 Port: d_wdata  in  32  store data.
REQ-013 Port: d_rdata  out  32  load data, valid with d_ack.
REQ-014 Port: d_ack  out  1  data completion, one-cycle pulse.
REQ-015 Port: mem_req  out  1  shared memory request, held until mem_ack.
REQ-016 Port: mem_we / mem_be / mem_addr / mem_wdata  out  1/4/32/32  latched command to memory.
REQ-017 Port: mem_rdata  in  32  memory read data, valid with mem_ack.
REQ-018 Port: mem_ack  in  1  memory completion.
REQ-019 Port: timeout_err  out  1  one-cycle pulse on forced completion.

Function
REQ-020 The block SHALL be an FSM with states IDLE, BUSY_I, BUSY_D; all outputs registered.
REQ-021 IDLE: eligible requester = req high AND own ack output not asserted this cycle; an acked requester is never re-granted in its ack cycle.
REQ-022 IDLE, one eligible: grant it; both eligible: grant the one not equal to last_grant (round-robin); none: stay IDLE.
REQ-023 On grant: next edge enter BUSY_x, set mem_req=1, latch addr/we/be/wdata, update last_grant, clear timeout counter.
REQ-024 I-grant SHALL drive mem_we=0, mem_be=4'b1111, mem_wdata=0; D-grant passes d_we, d_be, d_wdata.
REQ-025 BUSY_x: mem_req and command SHALL stay stable until mem_ack sampled high; requester input changes ignored.
REQ-026 BUSY_x with mem_ack=1: next edge x_ack=1 for one cycle, x_rdata<=mem_rdata (read) or held (write), mem_req=0, state IDLE.
REQ-027 Zero-wait memory: req-to-ack latency 2 cycles; peak throughput one transaction per 2 cycles.
REQ-028 BUSY_x with mem_ack=0: counter increments; when counter==TIMEOUT-1 and mem_ack=0, next edge x_ack=1, x_rdata=0, timeout_err=1, mem_req=0, IDLE.
REQ-029 mem_ack=1 on the timeout cycle SHALL take normal completion (REQ-026), no timeout_err.
REQ-030 mem_ack in IDLE SHALL be ignored.
REQ-031 i_ack and d_ack SHALL never be asserted in the same cycle.
REQ-032 x_rdata SHALL hold its value between acks.

Reset
REQ-033 reset low SHALL immediately force IDLE, last_grant=D, counter=0, all outputs 0 (mem_req drops mid-transaction, no ack issued).
REQ-034 After reset release, first simultaneous i_req/d_req SHALL grant I.

Verification
REQ-035 Reset, i_req=1 i_addr=0x100, mem_ack immediate with 0xDEADBEEF -> mem_req cycle1 addr 0x100 we=0 be=F, i_ack cycle2 i_rdata=0xDEADBEEF.
REQ-036 i_req and d_req held high continuously, zero-wait memory -> grants alternate I,D,I,D; one ack every 2 cycles; no double grant.
REQ-037 d_req we=1 be=0011 addr=0x2000 wdata=0x12345678, mem_ack after 5 cycles -> mem signals stable 5 cycles, d_ack one pulse, d_rdata unchanged.
REQ-038 TIMEOUT=4, d_req read, mem_ack never -> d_ack and timeout_err pulse together after 4 BUSY cycles, d_rdata=0, mem_req low, then IDLE.
REQ-039 reset asserted during BUSY_D with mem_req=1 -> mem_req 0 immediately, no d_ack; post-release tie grants I first.
